mdr_mem_access: RTL and testbench
=================================

# mdr_mem_access

Memory-side register stage of the datapath bus: holds the MAR and the MDR and runs the request/acknowledge handshake with data memory. Loads from the 32-bit bus, or from memory on a read, and returns its MDR contents as the bus multiplexer's MDR source (select code 5'b10101). Memory latency is variable. A bounded timeout with a sticky error flag prevents a missing acknowledge from hanging the datapath.

## Interface
- DATA_W, 32, bus/MDR/memory data width
- ADDR_W, 9, MAR and memory address width
- TIMEOUT, 16, maximum cycles mem_req stays high without mem_ack (legal range 2..255)

- clk  in  1  single clock, rising edge
- clr_n  in  1  asynchronous, active-low reset
- bus_in  in  DATA_W  datapath bus value
- mar_in  in  1  load MAR from bus_in[ADDR_W-1:0]
- mdr_in  in  1  MDR load strobe
- read  in  1  with mdr_in: load MDR from memory, otherwise from bus_in
- write  in  1  start memory write of MDR to MAR
- err_clr  in  1  clears err
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory acknowledge, one cycle
- mdr_out  out  DATA_W  MDR contents, feeds bus multiplexer MDR input
- mem_addr  out  ADDR_W  transaction address
- mem_wdata  out  DATA_W  write data
- mem_req  out  1  request, held until ack or timeout
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky protocol/timeout error

## Operation
- States: IDLE, READ, WRITE. Reset state is IDLE.
- Reset behaviour: every register and output is 0 (MAR, MDR, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err, timer).
- IDLE, mar_in=1: MAR <= bus_in[ADDR_W-1:0].
- IDLE, mdr_in=1, read=0: MDR <= bus_in. No memory traffic.
- IDLE, mdr_in=1, read=1: mem_addr <= MAR (old value if mar_in is asserted in the same cycle). Enter READ.
- IDLE, write=1: mem_addr <= MAR (old value), mem_wdata <= MDR, mem_we <= 1. Enter WRITE.
- Read start and write in the same cycle: the read wins, the write is dropped, and err is set.
- A bus load of MDR and write in the same cycle: the bus load happens, the write is dropped, and err is set.
- READ/WRITE with mem_ack=1: return to IDLE, done <= 1, timer <= 0. In READ, MDR <= mem_rdata.
- READ/WRITE, no ack, timer == TIMEOUT-1: abort to IDLE, set err, done stays 0, MDR unchanged.
- In READ/WRITE, any mar_in, mdr_in or write is ignored and sets err. MAR and MDR stay stable.
- err clears only on err_clr or reset. If err_clr and a new error occur in the same cycle, the new error wins (err = 1).
- mem_ack while in IDLE is ignored and sets no error.

## Timing
- All state updates on the rising edge of clk. clr_n forces reset values immediately, including dropping mem_req mid-transaction.
- Command accepted at edge k: mem_req=1 and busy=1 from edge k through the completing edge.
- Ack sampled at edge j: mem_req=0, busy=0 and done=1 for the cycle after j. In a read, mdr_out shows mem_rdata in that same cycle.
- Zero-wait memory (ack in the first request cycle): 2-cycle turnaround from command to done.
- Back-to-back: a new command is accepted in the done cycle.
- Bus-sourced MDR or MAR load: value visible on mdr_out / internal MAR one cycle later.
- Timer counts the request cycles that have no ack. The abort lands exactly TIMEOUT cycles after acceptance.

## Structure
- Shared package bus_pkg holds:
  - DATA_W and ADDR_W defaults
  - the bus select codes (SEL_MDR = 5'b10101, plus the other source codes)
  - the state encoding IDLE=2'd0, READ=2'd1, WRITE=2'd2
- One sub-module, access_timer: clears on start, increments while enabled, raises expired at TIMEOUT-1. Parameterised on TIMEOUT, width $clog2(TIMEOUT).
- The FSM, MAR, MDR and error logic stay in mdr_mem_access.

## Test plan
- Reset, then bus_in=32'hDEADBEEF with mdr_in=1, read=0 → next cycle mdr_out=32'hDEADBEEF, mem_req=0.
- MAR load 9'h05, then a read with memory acking 3 cycles later carrying 32'h12345678 → mem_addr=9'h05, mem_we=0, mem_req high for 4 cycles, done pulse once, mdr_out=32'h12345678.
- MDR=32'hA5A5A5A5, MAR=9'h1FF, write with zero-wait ack → mem_we=1, mem_wdata=32'hA5A5A5A5, done 2 cycles after the command, busy low afterwards.
- Read with no ack, TIMEOUT=16 → mem_req falls exactly 16 cycles after acceptance, err=1, done never set, MDR unchanged. err_clr → err=0.
- mar_in with bus_in=9'h0AA during a pending read, and read+write in the same IDLE cycle → MAR unchanged, err=1, only the read is issued.
- clr_n pulsed low mid-READ → mem_req, busy and mdr_out are 0 immediately. After release the block is in IDLE and a new read completes normally.

Source files
------------

// File: rtl/mdr_mem_access_pkg.sv
// bus_pkg: shared datapath bus widths, bus source select codes and access FSM encoding
package bus_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  typedef logic [4:0] busSel_t;
  localparam busSel_t SEL_NONE = 5'b00000;
  localparam busSel_t SEL_PC   = 5'b00001;
  localparam busSel_t SEL_IR   = 5'b00010;
  localparam busSel_t SEL_ALU  = 5'b00100;
  localparam busSel_t SEL_REG  = 5'b01000;
  localparam busSel_t SEL_MAR  = 5'b10100;
  localparam busSel_t SEL_MDR  = 5'b10101;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
endpackage

// File: rtl/mdr_mem_access_timer.sv
// access_timer: counts un-acknowledged request cycles and flags the last permitted one
module access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] count;
  assign expired = en && count == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) count <= '0;
    else count <= (start || !en || expired) ? '0 : count + 1'b1;
endmodule

// File: rtl/mdr_mem_access.sv
// mdr_mem_access: MAR/MDR register stage with req/ack data-memory handshake and timeout
module mdr_mem_access import bus_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);
  logic [1:0] state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic idle, readStart, writeStart, busLoad, newErr, expired;
  always_comb begin
    idle = state == IDLE;
    readStart = idle && mdr_in && read;
    busLoad = idle && mdr_in && !read;
    writeStart = idle && write && !mdr_in;
    // a write colliding with any MDR strobe is dropped; strobes while busy are protocol errors
    newErr = idle ? write && mdr_in : mar_in || mdr_in || write || expired;
  end
  assign mem_req = !idle;
  assign busy = !idle;
  assign mdr_out = mdr;
  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .clr_n(clr_n),
    .start(readStart || writeStart),
    .en(!idle && !mem_ack),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= IDLE;
      mar <= '0;
      mdr <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= !idle && mem_ack;
      err <= newErr || (err && !err_clr);
      if (idle) begin
        if (mar_in) mar <= bus_in[ADDR_W-1:0];
        if (busLoad) mdr <= bus_in;
        if (readStart || writeStart) begin
          mem_addr <= mar;
          mem_we <= writeStart;
          state <= readStart ? READ : WRITE;
        end
        if (writeStart) mem_wdata <= mdr;
      end else if (mem_ack || expired) begin
        if (state == READ && mem_ack) mdr <= mem_rdata;
        mem_we <= 1'b0;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_mdr_mem_access.sv
// tb_mdr_mem_access: random and directed stimulus against a transaction-level scoreboard
module tb_mdr_mem_access;
  localparam int DW = 32, AW = 9, TO = 16;
  logic clk = 0, clr_n = 0;
  logic [DW-1:0] bus_in = '0, mem_rdata = '0;
  logic mar_in = 0, mdr_in = 0, read = 0, write = 0, err_clr = 0, mem_ack = 0;
  logic [DW-1:0] mdr_out, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic mem_req, mem_we, busy, done, err;

  mdr_mem_access #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .read(read), .write(write), .err_clr(err_clr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mdr_out(mdr_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; int len;} req_t;
  req_t reqQ[$];
  logic [DW-1:0] doneQ[$];
  int errors = 0, checks = 0;
  logic [AW-1:0] refMar = '0;
  logic [DW-1:0] refMdr = '0;
  logic refErr = 0;
  int curLen = 0, seenLen = 0;
  logic prevReq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every new request and every done pulse is matched against the scoreboard
  always @(negedge clk)
    if (!clr_n) prevReq = 0;
    else begin
      if (mem_req && !prevReq) begin
        if (reqQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
          curLen = -1;
        end else begin
          req_t r;
          r = reqQ.pop_front();
          chk("req_addr", mem_addr, r.addr);
          chk("req_we", mem_we, r.we);
          if (r.we) chk("req_wdata", mem_wdata, r.wdata);
          curLen = r.len;
        end
        seenLen = 0;
      end
      if (mem_req) begin
        seenLen++;
        chk("busy_with_req", busy, 1);
      end
      if (!mem_req && prevReq && curLen >= 0) chk("req_len", seenLen, curLen);
      if (done) begin
        if (doneQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else chk("done_mdr", mdr_out, doneQ.pop_front());
      end
      prevReq = mem_req;
    end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // one IDLE command cycle plus, for a transaction, its wait/ack or timeout cycles
  task automatic op(input logic mi, input logic di, input logic rd, input logic wr, input logic cl,
                    input logic [DW-1:0] b, input int lat, input logic bad, input logic [DW-1:0] rdv);
    logic rs, ws;
    rs = di && rd;
    ws = wr && !di;
    if (rs || ws) reqQ.push_back('{refMar, ws, refMdr, lat >= TO ? TO : lat + 1});
    if (mi) refMar = b[AW-1:0];
    if (di && !rd) refMdr = b;
    refErr = (wr && di) ? 1'b1 : cl ? 1'b0 : refErr;
    mar_in = mi; mdr_in = di; read = rd; write = wr; err_clr = cl; bus_in = b;
    mem_ack = 1'($urandom_range(0, 1));
    cyc;
    mar_in = 0; mdr_in = 0; read = 0; write = 0; err_clr = 0; mem_ack = 0;
    if (rs || ws) begin
      if (bad) begin
        mar_in = 1;
        bus_in = $urandom;
        refErr = 1;
      end
      if (lat >= TO) begin
        repeat (TO) begin
          cyc;
          mar_in = 0;
        end
        refErr = 1;
        chk("abort_req", mem_req, 0);
        chk("abort_err", err, 1);
      end else begin
        repeat (lat) begin
          cyc;
          mar_in = 0;
        end
        mem_ack = 1;
        mem_rdata = rdv;
        cyc;
        mar_in = 0;
        mem_ack = 0;
        mem_rdata = $urandom;
        if (rs) refMdr = rdv;
        doneQ.push_back(refMdr);
      end
    end
    chk("err", err, refErr);
    chk("mdr", mdr_out, refMdr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_mdr", mdr_out, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    clr_n = 1;
    cyc;
    op(0, 1, 0, 0, 0, 32'hDEADBEEF, 0, 0, '0);
    chk("bus_load_noreq", mem_req, 0);
    op(1, 0, 0, 0, 0, 32'h005, 0, 0, '0);
    op(0, 1, 1, 0, 0, '0, 3, 0, 32'h12345678);
    op(0, 1, 0, 0, 0, 32'hA5A5A5A5, 0, 0, '0);
    op(1, 0, 0, 0, 0, 32'h1FF, 0, 0, '0);
    op(0, 0, 0, 1, 0, '0, 0, 0, '0);
    chk("write_busy_after", busy, 0);
    op(0, 1, 1, 0, 0, '0, TO, 0, '0);
    op(0, 0, 0, 0, 1, '0, 0, 0, '0);
    op(0, 1, 1, 0, 0, '0, 2, 1, $urandom);
    op(0, 1, 1, 0, 0, '0, 1, 0, $urandom);
    op(0, 0, 0, 0, 1, '0, 0, 0, '0);
    op(0, 1, 1, 1, 0, '0, 0, 0, 32'hCAFEF00D);
    op(0, 0, 0, 0, 1, '0, 0, 0, '0);
    op(0, 1, 1, 0, 0, '0, TO - 1, 0, 32'h0BADCAFE);
    op(0, 1, 0, 1, 1, 32'h13572468, 0, 0, '0);
    op(1, 1, 1, 0, 0, 32'h0AA, 0, 0, 32'h55AA55AA);
    op(0, 1, 1, 0, 0, '0, 0, 0, 32'h77777777);
    // reset while a read is outstanding
    reqQ.push_back('{refMar, 1'b0, refMdr, 0});
    mdr_in = 1; read = 1;
    cyc;
    mdr_in = 0; read = 0;
    cyc;
    clr_n = 0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mdr", mdr_out, 0);
    cyc;
    clr_n = 1;
    refMar = '0; refMdr = '0; refErr = 0;
    chk("rst_mid_err", err, 0);
    op(1, 0, 0, 0, 0, 32'h033, 0, 0, '0);
    op(0, 1, 1, 0, 0, '0, 1, 0, 32'hFEEDFACE);
    for (int n = 0; n < 60; n++) begin
      int k, lat;
      k = $urandom_range(0, 6);
      lat = $urandom_range(0, TO + 3);
      if (lat > TO) lat = $urandom_range(0, 4);
      case (k)
        0: op(0, 1, 0, 0, 0, $urandom, 0, 0, '0);
        1: op(1, 0, 0, 0, 0, $urandom, 0, 0, '0);
        2: op(0, 1, 1, 0, 0, $urandom, lat, 1'($urandom_range(0, 1)), $urandom);
        3: op(0, 0, 0, 1, 0, $urandom, lat, 1'($urandom_range(0, 1)), $urandom);
        4: op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, lat, 0, $urandom);
        5: op(0, 0, 0, 0, 1, $urandom, 0, 0, '0);
        default: op(0, 0, 0, 0, 0, $urandom, 0, 0, '0);
      endcase
    end
    cyc;
    cyc;
    chk("req_queue_drained", reqQ.size(), 0);
    chk("done_queue_drained", doneQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
